sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//   Serializes a parallel bit pattern onto a single-bit line, MSB first, one bit per clk.
//   Drives the serial input of our sequence detectors, e.g. pattern 1001 for the 1001 detector.
//   Used as an on-chip stimulus source and as a loopback partner for detector self-test.
// PARAMETERS
//   PAT_W  4  pattern width in bits; legal range 2..32
//   CNT_W  4  width of the repeat count
// PORTS
//   clk         in   1      rising-edge clock (single clock domain)
//   reset       in   1      asynchronous, active-high reset
//   start       in   1      request to send; accepted only when ready=1
//   pattern     in   PAT_W  pattern to send; sampled when start is accepted
//   repeat_cnt  in   CNT_W  number of extra back-to-back repetitions; sampled when start is accepted
//   ready       out  1      idle and able to accept start
//   out         out  1      serial data bit
//   out_valid   out  1      out carries a pattern bit this cycle
//   done        out  1      one-cycle pulse after the final bit
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async, any time, including mid-send):
//     state=IDLE, ready=1, out=0, out_valid=0, done=0; shift register and counters cleared.
//   - FSM states: IDLE, SHIFT, DONE.
//   - IDLE: start&&ready at edge T
//     -> SHIFT; latch pattern and repeat_cnt; ready<=0.
//     -> out<=pattern[PAT_W-1], out_valid<=1; bit_idx<=PAT_W-2.
//     -> first bit is visible in the cycle after T (latency 1).
//   - SHIFT: each edge emits pat_reg[bit_idx], then bit_idx decrements.
//     - After bit 0 with reps_left>0: reps_left--, bit_idx wraps to PAT_W-1, no idle gap.
//     - After bit 0 with reps_left==0: -> DONE; out<=0, out_valid<=0, done<=1.
//   - DONE: exactly one cycle -> IDLE; done<=0, ready<=1.
//   - Valid cycles per transaction = PAT_W*(repeat_cnt+1), always contiguous.
//   - start while ready=0 (SHIFT or DONE) is ignored, not queued.
//   - pattern and repeat_cnt changes after acceptance have no effect.
//   - out=0 whenever out_valid=0.
//   - repeat_cnt is unsigned. Max value 2^CNT_W-1 gives 2^CNT_W repetitions; no overflow wrap.
// CONFIGURATION
//   SEQ_GEN_REPEAT_EN
//     defined:   repeat_cnt honoured as above.
//     undefined: repeat_cnt is ignored and no reps counter is built; pattern is sent exactly once.
//     The port remains in both cases so the interface is fixed.
// STRUCTURE
//   - Package seq_pkg holds:
//     - typedef gen_state_t {IDLE, SHIFT, DONE}, 2 bits;
//     - localparam widths shared with the detectors;
//     - constant PAT_1001 = 4'b1001.
//   - Sub-module seq_piso: loadable PAT_W-bit parallel-in/serial-out shift register, MSB first.
//   - The FSM, bit index counter and repetition counter stay in sequence_generator.
// TESTING
//   1. Reset check: hold reset high mid-SHIFT for 2 cycles
//      -> ready=1, out=0, out_valid=0, done=0 immediately; next start works normally.
//   2. Single send: pattern=4'b1001, repeat_cnt=0, start 1 cycle
//      -> out=1,0,0,1 with out_valid=1 for 4 cycles starting cycle T+1; done=1 at T+5; ready=1 at T+6.
//   3. Repeat (SEQ_GEN_REPEAT_EN): pattern=4'b1001, repeat_cnt=2
//      -> 12 contiguous valid bits 100110011001; one done pulse after the 12th bit.
//   4. Repeat compiled out: same stimulus as 3 -> 4 bits 1001 only, done after the 4th bit.
//   5. Busy rejection: start pulsed during SHIFT and during DONE
//      -> no extra bits sent; ready stays 0 until IDLE.
//   6. Loopback: drive out into sequence_detector_1001 input, pattern=4'b1001, repeat_cnt=1
//      -> detector output pulses twice, matching the overlapping detections in 10011001.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type, widths and patterns for sequence generators/detectors
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } gen_state_t;

  localparam int SEQ_PAT_W = 4;
  localparam int SEQ_CNT_W = 4;

  localparam logic [SEQ_PAT_W-1:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - loadable parallel-in/serial-out register, MSB first
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         shift,
  output logic         sout
);

  logic [W-1:0] sr;

  // Rotating rather than shifting lets repeated sends recirculate without a reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {sr[W-2:0], sr[W-1]};
    end
  end

  assign sout = sr[W-1];

endmodule

// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - MSB-first pattern serializer; SEQ_GEN_REPEAT_EN enables repeat_cnt
module sequence_generator
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);

  gen_state_t       state, state_n;
  logic [IDX_W-1:0] bit_idx;
  logic             last_out;
  logic             piso_load, piso_shift, piso_bit;
  logic             more_reps, accept, emit, wrap;
  logic             out_n, out_valid_n, done_n, ready_n;

  // The MSB goes straight to out on acceptance, so the register starts one bit ahead.
  seq_piso #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (piso_load),
    .data  ({pattern[PAT_W-2:0], pattern[PAT_W-1]}),
    .shift (piso_shift),
    .sout  (piso_bit)
  );

  assign accept = start && ready && (state == IDLE);
  assign wrap   = (state == SHIFT) && last_out && more_reps;
  assign emit   = (state == SHIFT) && (!last_out || more_reps);

`ifdef SEQ_GEN_REPEAT_EN
  logic [CNT_W-1:0] reps_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reps_left <= '0;
    end else if (accept) begin
      reps_left <= repeat_cnt;
    end else if (wrap) begin
      reps_left <= reps_left - CNT_W'(1);
    end
  end

  assign more_reps = (reps_left != '0);
`else
  logic unused_repeat;
  assign unused_repeat = ^repeat_cnt;
  assign more_reps     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (last_out && !more_reps) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_n       = 1'b0;
    out_valid_n = 1'b0;
    done_n      = 1'b0;
    ready_n     = 1'b0;
    piso_load   = accept;
    piso_shift  = emit;
    case (state)
      IDLE: begin
        ready_n = !accept;
        if (accept) begin
          out_n       = pattern[PAT_W-1];
          out_valid_n = 1'b1;
        end
      end
      SHIFT: begin
        if (emit) begin
          out_n       = piso_bit;
          out_valid_n = 1'b1;
        end else begin
          done_n = 1'b1;
        end
      end
      default: ready_n = 1'b1;
    endcase
  end

  // last_out marks that the bit currently on out is bit 0 of the pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready     <= 1'b1;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
      last_out  <= 1'b0;
    end else begin
      ready     <= ready_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      done      <= done_n;
      if (accept || wrap) begin
        bit_idx  <= IDX_W'(PAT_W - 2);
        last_out <= 1'b0;
      end else if (emit) begin
        bit_idx  <= bit_idx - IDX_W'(1);
        last_out <= (bit_idx == '0);
      end
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// tb/tb_sequence_generator.sv - self-checking bench for sequence_generator
module tb_sequence_generator;
  import seq_pkg::*;

  localparam int PAT_W = SEQ_PAT_W;
  localparam int CNT_W = SEQ_CNT_W;
`ifdef SEQ_GEN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             ready, out, out_valid, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .ready      (ready),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );

  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rc;
    int               len_rep;
    bit               busy;
  } vec_t;

  vec_t vecs[7];
  bit   got[$];
  bit   exp_q[$];

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic build_expected(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rc);
    int reps;
    reps = REP_EN ? int'(rc) : 0;
    exp_q.delete();
    for (int r = 0; r <= reps; r++)
      for (int b = PAT_W - 1; b >= 0; b--)
        exp_q.push_back(pat[b]);
  endtask

  function automatic int count_1001();
    logic [3:0] win;
    int hits;
    win  = '0;
    hits = 0;
    foreach (got[i]) begin
      win = {win[2:0], got[i]};
      if (i >= 3 && win == PAT_1001) hits++;
    end
    return hits;
  endfunction

  task automatic do_txn(input string tag, input logic [PAT_W-1:0] pat,
                        input logic [CNT_W-1:0] rc, input int explen, input bit busy);
    int first_v, last_v, gap, zero_bad, done_cnt, done_cyc, ready_cyc, mism, extra;
    first_v = -1; last_v = -1; gap = 0; zero_bad = 0;
    done_cnt = 0; done_cyc = -1; ready_cyc = -1; mism = 0; extra = 0;
    got.delete();
    build_expected(pat, rc);

    @(negedge clk);
    chk({tag, "_ready_before"}, ready, 1);
    start = 1'b1; pattern = pat; repeat_cnt = rc;
    @(negedge clk);
    start = 1'b0;
    pattern = PAT_W'($urandom);
    repeat_cnt = CNT_W'($urandom);

    for (int c = 1; c <= 200; c++) begin
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        else if (last_v != c - 1) gap++;
        last_v = c;
        got.push_back(out);
      end else if (out) begin
        zero_bad++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (ready) begin
        ready_cyc = c;
        break;
      end
      if (busy) start = (c == 2) || done;
      @(negedge clk);
    end
    start = 1'b0;

    foreach (exp_q[i])
      if (i < got.size() && got[i] != exp_q[i]) mism++;

    chk({tag, "_len"}, got.size(), explen);
    chk({tag, "_model_len"}, got.size(), exp_q.size());
    chk({tag, "_bit_errors"}, mism, 0);
    chk({tag, "_first_valid_cycle"}, first_v, 1);
    chk({tag, "_gaps"}, gap, 0);
    chk({tag, "_out_nonzero_idle"}, zero_bad, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, explen + 1);
    chk({tag, "_ready_cycle"}, ready_cyc, explen + 2);

    repeat (3) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk({tag, "_extra_bits"}, extra, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; repeat_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;

    vecs[0] = '{4'b1001, 4'd0,  4,  1'b0};
    vecs[1] = '{4'b1001, 4'd2,  12, 1'b0};
    vecs[2] = '{4'b0110, 4'd1,  8,  1'b0};
    vecs[3] = '{4'b1111, 4'd15, 64, 1'b0};
    vecs[4] = '{4'b0000, 4'd3,  16, 1'b0};
    vecs[5] = '{4'b1001, 4'd2,  12, 1'b1};
    vecs[6] = '{4'b1010, 4'd0,  4,  1'b1};

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].pat, vecs[i].rc,
             REP_EN ? vecs[i].len_rep : PAT_W, vecs[i].busy);

    // asynchronous reset in the middle of a send
    @(negedge clk);
    start = 1'b1; pattern = 4'b1011; repeat_cnt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ready", ready, 1);
    chk("rst_async_out", out, 0);
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_ready", ready, 1);
    chk("rst_hold_valid", out_valid, 0);
    reset = 1'b0;
    do_txn("after_rst", 4'b1001, 4'd0, PAT_W, 1'b0);

    do_txn("loop", PAT_1001, 4'd1, REP_EN ? 8 : 4, 1'b0);
    chk("loop_detections", count_1001(), REP_EN ? 2 : 1);

    for (int i = 0; i < 15; i++) begin
      logic [PAT_W-1:0] rp;
      logic [CNT_W-1:0] rr;
      rp = PAT_W'($urandom);
      rr = CNT_W'($urandom_range(0, 15));
      do_txn($sformatf("rnd%0d", i), rp, rr,
             PAT_W * (REP_EN ? int'(rr) + 1 : 1), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
